fsm_stream_sched: RTL and testbench
===================================

# fsm_stream_sched

Round-robin scheduler that shares one serial detector FSM (single-bit input `a`, registered flags `out1`/`out2`) between two requesters. Each requester submits a WIDTH-bit pattern word. The block grants one requester, shifts its word MSB-first into the detector one bit per clock, counts `out1`/`out2` assertions for that word, and reports the counts with a one-cycle `done` pulse. It sits between the pattern sources and the detector and is the only driver of the detector's `a` input.

## Interface
- WIDTH, 8, bits per pattern word (≥2)
- CNT_W, 4, width of each hit counter (saturating)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 has a word pending; hold until gnt0
- data0  in  WIDTH  requester 0 word; stable while req0=1
- req1  in  1  requester 1 request
- data1  in  WIDTH  requester 1 word
- gnt0  out  1  one-cycle pulse: data0 captured
- gnt1  out  1  one-cycle pulse: data1 captured
- a  out  1  serial bit to detector
- out1  in  1  detector flag 1, reflects previous cycle's `a`
- out2  in  1  detector flag 2, reflects previous cycle's `a`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: result valid
- done_id  out  1  requester that owned the reported word
- hit1_cnt  out  CNT_W  out1 assertions for the word
- hit2_cnt  out  CNT_W  out2 assertions for the word

## Operation
- States: IDLE, SHIFT, DRAIN, REPORT.
- IDLE:
  - a=0.
  - If req0 or req1 is high, latch the winner's data into the shift register, set owner, clear both counters, bitcnt=0, go to SHIFT.
- Arbitration:
  - Single request wins.
  - If both are high, grant the requester that is not `last`, then update `last` to the winner.
  - `last` resets to 1, so requester 0 wins the first tie.
- SHIFT:
  - a = shreg[WIDTH-1]; shift left each cycle; bitcnt increments.
  - On the first SHIFT cycle, gnt<owner> is high for exactly one cycle.
  - From bitcnt≥1, add out1/out2 to the counters.
  - After bitcnt=WIDTH-1, go to DRAIN.
- DRAIN: a=0; sample out1/out2 one final time, covering the last bit; go to REPORT.
- REPORT: a=0; done=1; done_id=owner; go to IDLE.
- Counting:
  - Exactly WIDTH samples per word.
  - Counters saturate at 2^CNT_W−1 and never wrap.
- Requests:
  - A req seen in any non-IDLE state is ignored, not queued.
  - A requester that keeps req high after its gnt is treated as a new request at the next IDLE.
- Separation: at least two a=0 cycles (DRAIN, REPORT) always separate consecutive words.
- Reset mid-operation:
  - Abort the word; go to IDLE.
  - No done and no gnt is issued for the aborted word.
  - last=1.

## Timing
- Reset values:
  - state=IDLE, a=0, gnt0=gnt1=0, busy=0, done=0, done_id=0, hit1_cnt=hit2_cnt=0, last=1, shreg=0, bitcnt=0.
- Request accepted in IDLE cycle T:
  - T+1: gnt pulse, SHIFT begins, a=MSB.
  - Bits are driven in T+1..T+WIDTH.
  - DRAIN at T+WIDTH+1.
  - done at T+WIDTH+2.
  - IDLE at T+WIDTH+3.
- Grant-to-done latency is WIDTH+1 cycles.
- Back-to-back requests: next accept at T+WIDTH+3, next gnt at T+WIDTH+4.
- Throughput is one word per WIDTH+3 cycles.
- hit1_cnt, hit2_cnt and done_id hold their values after done until the next accept clears the counters.

## Test plan
Stub detector for all scenarios: out1 = a delayed one cycle, out2 = ~a delayed one cycle. WIDTH=8, CNT_W=4.
- Reset, then idle 5 cycles → a=0, busy=0, done=0, gnt0=gnt1=0, counters=0.
- req0 with data0=8'b1011_0010, accepted at T:
  - gnt0 at T+1 only.
  - a sequence 1,0,1,1,0,0,1,0 over T+1..T+8.
  - done at T+10 with done_id=0, hit1_cnt=4, hit2_cnt=4.
- req0 and req1 both held high, data0=8'hFF, data1=8'h00:
  - Grants alternate 0,1,0.
  - Results (hit1,hit2): (8,0) id0, then (0,8) id1, then (8,0) id0.
  - Grants are 11 cycles apart.
- req1 asserted during a req0 word → no gnt1 until the cycle after the req0 done's IDLE acceptance; the req0 word's counts are unaffected.
- CNT_W=3 with data0=8'hFF → hit1_cnt saturates at 7, hit2_cnt=0.
- rst asserted on the 4th SHIFT cycle:
  - Next cycle shows a=0, busy=0, with no done.
  - After release, req1 and req0 both high: req0 wins, since last=1.

Source files
------------

// File: rtl/fsm_stream_sched.sv
// rtl/fsm_stream_sched.sv - round-robin scheduler feeding one serial detector and counting its hits per word
module fsm_stream_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             a,
    input  logic             out1,
    input  logic             out2,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] hit1_cnt,
    output logic [CNT_W-1:0] hit2_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] hit1;
    logic [CNT_W-1:0] hit2;
    logic             accept;
    logic             win;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Arbitration: a lone request wins; on a tie the requester that did not win the last tie goes.
    always_comb begin
        win    = (req0 && req1) ? ~last : req1;
        accept = (state == IDLE) && (req0 || req1);
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt = state;
        a         = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                a    = shreg[WIDTH-1];
                gnt0 = (bitcnt == '0) && !owner;
                gnt1 = (bitcnt == '0) && owner;
                if (bitcnt == LAST_BIT) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = REPORT;
            REPORT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Word capture, shifting and hit counting; flags lag a by one cycle so the first SHIFT sample is skipped and DRAIN picks up the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bitcnt <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
            hit1   <= '0;
            hit2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg  <= win ? data1 : data0;
                        owner  <= win;
                        bitcnt <= '0;
                        hit1   <= '0;
                        hit2   <= '0;
                        if (req0 && req1) last <= win;
                    end
                end
                SHIFT: begin
                    shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt + BW'(1);
                    if (bitcnt != '0) begin
                        hit1 <= sat_inc(hit1, out1);
                        hit2 <= sat_inc(hit2, out2);
                    end
                end
                DRAIN: begin
                    hit1 <= sat_inc(hit1, out1);
                    hit2 <= sat_inc(hit2, out2);
                end
                default: ;
            endcase
        end
    end

    assign done_id  = owner;
    assign hit1_cnt = hit1;
    assign hit2_cnt = hit2;

endmodule

// File: tb/tb_fsm_stream_sched.sv
// tb/tb_fsm_stream_sched.sv - randomized self-checking bench for fsm_stream_sched against a schedule-level model
module tb_fsm_stream_sched;

    localparam int W = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic gnt0, gnt1, a, busy, done, done_id;
    logic out1 = 1'b0, out2 = 1'b0;
    logic [CW-1:0] hit1_cnt, hit2_cnt;

    logic req0_s = 1'b1, req1_s = 1'b0;
    logic [W-1:0] data0_s = 8'hFF, data1_s = 8'h00;
    logic gnt0_s, gnt1_s, a_s, busy_s, done_s, done_id_s;
    logic out1_s = 1'b0, out2_s = 1'b0;
    logic [2:0] hit1_s, hit2_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int seen_s = 0;

    bit m_has = 0;
    int m_t = 0;
    logic [W-1:0] m_word = '0;
    bit m_id = 0;
    bit m_last = 1;
    int m_h1 = 0, m_h2 = 0;
    bit m_acc = 0;
    bit m_acc_id = 0;

    fsm_stream_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .a(a), .out1(out1), .out2(out2), .busy(busy),
        .done(done), .done_id(done_id), .hit1_cnt(hit1_cnt), .hit2_cnt(hit2_cnt)
    );

    fsm_stream_sched #(.WIDTH(W), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .req0(req0_s), .data0(data0_s), .req1(req1_s), .data1(data1_s),
        .gnt0(gnt0_s), .gnt1(gnt1_s), .a(a_s), .out1(out1_s), .out2(out2_s), .busy(busy_s),
        .done(done_s), .done_id(done_id_s), .hit1_cnt(hit1_s), .hit2_cnt(hit2_s)
    );

    always #5 clk = ~clk;

    // Stub detectors: out1 is a delayed, out2 is ~a delayed.
    always @(posedge clk) begin
        out1   <= a;
        out2   <= ~a;
        out1_s <= a_s;
        out2_s <= ~a_s;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic bit m_idle();
        return !m_has || (cyc >= m_t + W + 3);
    endfunction

    // Expected outputs follow from the accept cycle: bits at T+1..T+W, done at T+W+2.
    task automatic check_outputs();
        int r;
        bit busy_e, a_e, done_e;
        r = cyc - m_t;
        busy_e = m_has && r >= 1 && r <= W + 2;
        a_e    = (m_has && r >= 1 && r <= W) ? m_word[W - r] : 1'b0;
        done_e = m_has && r == W + 2;
        check("a", int'(a), int'(a_e));
        check("busy", int'(busy), int'(busy_e));
        check("done", int'(done), int'(done_e));
        check("gnt0", int'(gnt0), int'(m_has && r == 1 && !m_id));
        check("gnt1", int'(gnt1), int'(m_has && r == 1 && m_id));
        if (!busy_e || done_e) begin
            check("done_id", int'(done_id), int'(m_id));
            check("hit1_cnt", int'(hit1_cnt), m_h1);
            check("hit2_cnt", int'(hit2_cnt), m_h2);
        end
        if (done_s) begin
            seen_s++;
            check("sat_hit1", int'(hit1_s), 7);
            check("sat_hit2", int'(hit2_s), 0);
        end
    endtask

    task automatic run(input int n);
        int pop;
        bit w;
        repeat (n) begin
            m_acc = 0;
            if (rst) begin
                m_has = 0; m_last = 1; m_id = 0; m_h1 = 0; m_h2 = 0;
            end else if (m_idle() && (req0 || req1)) begin
                w = (req0 && req1) ? !m_last : req1;
                if (req0 && req1) m_last = w;
                m_has = 1; m_t = cyc; m_id = w;
                m_word = w ? data1 : data0;
                pop = $countones(m_word);
                m_h1 = sat(pop); m_h2 = sat(W - pop);
                m_acc = 1; m_acc_id = w;
            end
            @(posedge clk);
            cyc++;
            #1;
            check_outputs();
        end
    endtask

    initial begin
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);

        req0 = 1'b1; data0 = 8'b1011_0010;
        run(1);
        req0 = 1'b0;
        run(12);

        req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; data1 = 8'h00;
        run(33);
        req0 = 1'b0; req1 = 1'b0;
        run(12);

        req0 = 1'b1; data0 = 8'h5C;
        run(1);
        req0 = 1'b0;
        run(3);
        req1 = 1'b1; data1 = 8'hA7;
        run(9);
        run(1);
        req1 = 1'b0;
        run(12);

        req0 = 1'b1; data0 = 8'h3D;
        run(1);
        req0 = 1'b0;
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hC3; data1 = 8'h18;
        run(1);
        req0 = 1'b0; req1 = 1'b0;
        run(12);

        for (int i = 0; i < 400; i++) begin
            if (!req0 && ($urandom % 3 == 0)) begin req0 = 1'b1; data0 = 8'($urandom); end
            if (!req1 && ($urandom % 3 == 0)) begin req1 = 1'b1; data1 = 8'($urandom); end
            rst = ($urandom % 150 == 0);
            run(1);
            if (m_acc) begin
                if (m_acc_id == 1'b0) begin req0 = ($urandom % 4 == 0); data0 = 8'($urandom); end
                else                  begin req1 = ($urandom % 4 == 0); data1 = 8'($urandom); end
            end
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        run(14);

        check("sat_seen", int'(seen_s > 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
